// File: rtl/mxu_operand_loader.sv
// -----------------------------------------------------------------------------
// mxu_operand_loader
//
// Collects a stream of 2*DIM*DIM two's-complement elements (A row-major first,
// then B row-major) into the operand banks of a DIM x DIM matrix unit, pulses
// start for one cycle once both banks are full, and holds the banks stable
// until the MXU reports completion.
//
// Optional feature (macro MXU_LOADER_DOUBLE_BUF_EN):
//   When defined, shadow A/B banks accept the next operand pair while the MXU
//   computes. On completion a full shadow set is copied to the active banks
//   and the MXU is restarted straight away. A partial shadow set is also
//   copied, and the load then carries on into the active banks from the
//   current index.
//
// Parameters:
//   DIM        matrix dimension (A and B are DIM x DIM)
//   BIT_WIDTH  element width
//
// Ports:
//   clk            clock
//   reset_n        asynchronous active-low reset
//   in_valid       element stream valid
//   in_ready       element stream ready
//   in_data        element value
//   abort          flushes the load in progress
//   mxu_out_valid  completion flag from the MXU
//   start          one-cycle MXU start pulse
//   A, B           active banks, packed [DIM][DIM][BIT_WIDTH]; element [r][c]
//                  sits at bits (r*DIM+c)*BIT_WIDTH upward
//   busy           high while the MXU works on the active banks
// -----------------------------------------------------------------------------
module mxu_operand_loader #(
    parameter int DIM       = 16,
    parameter int BIT_WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [BIT_WIDTH-1:0]         in_data,
    input  logic                         abort,
    input  logic                         mxu_out_valid,
    output logic                         start,
    output logic [DIM*DIM*BIT_WIDTH-1:0] A,
    output logic [DIM*DIM*BIT_WIDTH-1:0] B,
    output logic                         busy
);

    localparam int NEL   = DIM * DIM;
    localparam int TOTAL = 2 * NEL;
    localparam int IDX_W = $clog2(TOTAL);
    localparam int RC_W  = (DIM > 1) ? $clog2(DIM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);
    localparam logic [IDX_W-1:0] B_BASE   = IDX_W'(NEL);

    typedef logic [DIM-1:0][DIM-1:0][BIT_WIDTH-1:0] bank_t;
    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_FIRE = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;
    bank_t            a_bank;
    bank_t            b_bank;

    logic             accept;
    logic             last;
    logic             done;
    logic             load_take;
    logic             take;
    logic             clear_idx;
    logic             wr_active;
    logic             to_b;
    int               offset;
    logic [RC_W-1:0]  row;
    logic [RC_W-1:0]  col;

    assign A = a_bank;
    assign B = b_bank;

    // Element index -> bank select and row/column within that bank.
    always_comb begin
        to_b   = (idx >= B_BASE);
        offset = to_b ? (int'(idx) - NEL) : int'(idx);
        row    = RC_W'(offset / DIM);
        col    = RC_W'(offset % DIM);
    end

    assign accept    = in_valid & in_ready;
    assign last      = (idx == LAST_IDX);
    // Only the WAIT state listens to the MXU; once we leave WAIT a level that
    // stays high cannot complete the same job twice.
    assign done      = (state == ST_WAIT) & mxu_out_valid;
    // Abort wins over an element handshaken in the same cycle.
    assign load_take = (state == ST_LOAD) & accept & ~abort;

`ifdef MXU_LOADER_DOUBLE_BUF_EN
    bank_t sh_a_bank;
    bank_t sh_b_bank;
    logic  shadow_full;
    logic  shadow_take;
    logic  refire;

    assign shadow_take = (state == ST_WAIT) & accept & ~abort;
    // A final shadow element arriving together with completion counts as full.
    assign refire      = done & (shadow_full | (shadow_take & last));
    assign take        = load_take | shadow_take;
    assign clear_idx   = abort & ((state == ST_LOAD) | (state == ST_WAIT));
    // An element landing in the completion cycle must also reach the active
    // banks, since the shadow copy taken that cycle does not contain it.
    assign wr_active   = load_take | (shadow_take & done);
`else
    assign take        = load_take;
    assign clear_idx   = abort & (state == ST_LOAD);
    assign wr_active   = load_take;
`endif

    // ---- state register ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_LOAD;
        end else begin
            state <= state_next;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        state_next = state;
        case (state)
            ST_LOAD: begin
                if (load_take && last) begin
                    state_next = ST_FIRE;
                end
            end
            ST_FIRE: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (done) begin
`ifdef MXU_LOADER_DOUBLE_BUF_EN
                    state_next = refire ? ST_FIRE : ST_LOAD;
`else
                    state_next = ST_LOAD;
`endif
                end
            end
            default: begin
                state_next = ST_LOAD;
            end
        endcase
    end

    // ---- output logic ----
    always_comb begin
        in_ready = 1'b0;
        start    = 1'b0;
        busy     = 1'b0;
        case (state)
            ST_LOAD: begin
                in_ready = 1'b1;
            end
            ST_FIRE: begin
                start = 1'b1;
                busy  = 1'b1;
            end
            ST_WAIT: begin
                busy = 1'b1;
`ifdef MXU_LOADER_DOUBLE_BUF_EN
                in_ready = ~shadow_full;
`endif
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // ---- element counter ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx <= '0;
        end else if (clear_idx) begin
            idx <= '0;
        end else if (take) begin
            idx <= last ? '0 : idx + IDX_W'(1);
        end
    end

    // ---- active banks ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_bank <= '0;
            b_bank <= '0;
        end else begin
`ifdef MXU_LOADER_DOUBLE_BUF_EN
            if (done) begin
                a_bank <= sh_a_bank;
                b_bank <= sh_b_bank;
            end
`endif
            if (wr_active) begin
                if (to_b) begin
                    b_bank[row][col] <= in_data;
                end else begin
                    a_bank[row][col] <= in_data;
                end
            end
        end
    end

`ifdef MXU_LOADER_DOUBLE_BUF_EN
    // ---- shadow banks ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_a_bank   <= '0;
            sh_b_bank   <= '0;
            shadow_full <= 1'b0;
        end else begin
            if (shadow_take) begin
                if (to_b) begin
                    sh_b_bank[row][col] <= in_data;
                end else begin
                    sh_a_bank[row][col] <= in_data;
                end
            end
            if (done) begin
                shadow_full <= 1'b0;
            end else if (shadow_take && last) begin
                shadow_full <= 1'b1;
            end
        end
    end
`endif

endmodule
